mux: RTL and testbench
======================

MUX -- requirements
Module: mux

Interface
REQ-001 Parameter WIDTH, default 1: bit width of data inputs a, b and data outputs out, out_q; legal range 1..64.
REQ-002 clk  input  1  single clock; all sequential logic on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 a  input  WIDTH  data input selected when sel=0.
REQ-005 b  input  WIDTH  data input selected when sel=1.
REQ-006 sel  input  1  select: 0 -> a, 1 -> b.
REQ-007 en  input  1  registered-path load enable.
REQ-008 out  output  WIDTH  combinational mux result.
REQ-009 out_q  output  WIDTH  registered mux result.
REQ-010 sel_q  output  1  registered copy of sel, loaded alongside out_q.

Function
REQ-011 out SHALL equal a when sel=0 and b when sel=1, bit for bit, for every WIDTH.
REQ-012 out SHALL be purely combinational: zero-cycle latency, settling within the same delta step as its inputs, independent of clk, reset and en.
REQ-013 For WIDTH=1, out SHALL follow the truth table (a,b,sel -> out): 000->0, 001->0,010->0, 011->1, 100->1, 101->0, 110->1, 111->1.
REQ-014 On a rising clk edge with reset=0 and en=1, out_q SHALL load (sel ? b : a) and sel_q SHALL load sel; latency one cycle.
REQ-015 On a rising clk edge with reset=0 and en=0, out_q and sel_q SHALL hold their values.
REQ-016 On a rising clk edge with reset=1, out_q and sel_q SHALL load 0 regardless of en, sel, a, b (reset has priority over en).
REQ-017 Input changes between clock edges SHALL affect out immediately and out_q only at the next qualifying edge.
REQ-018 When sel and data change in the same cycle, out_q SHALL capture the new sel applied to the new data.
REQ-019 When sel is X/Z, out is unspecified; synthesis SHALL NOT add logic for this case.
REQ-020 The block SHALL contain no latches and no combinational loops; out SHALL NOT depend on out_q.

Reset
REQ-021 Reset SHALL be sampled only on rising clk (synchronous); asserting reset between edges SHALL NOT change out_q or sel_q until the next edge.
REQ-022 Reset values: out_q = 0 (all WIDTH bits), sel_q = 0; out is unaffected by reset and keeps tracking a, b, sel.
REQ-023 Reset asserted mid-operation SHALL clear out_q and sel_q at the next edge; after release, the first edge with en=1 SHALL load normally.
REQ-024 Before the first reset edge, out_q and sel_q values are undefined; out is valid from time zero.

Structure
REQ-025 Single flat module mux; no shared package is required, since WIDTH is the only constant and is a module parameter.
REQ-026 No sub-modules; the combinational select and the output register SHALL be in this module, the register path reusing the combinational result.
REQ-027 The module SHALL be synthesizable and lint-clean for WIDTH=1 and WIDTH=8.

Verification
REQ-028 Exhaustive WIDTH=1 combinational: step all 8 (a,b,sel) combinations, 1 time unit apart, no clock -> out matches the REQ-013 table at each step.
REQ-029 Reset: drive a=1, b=1, sel=1, en=1, reset=1 for one edge -> out_q=0, sel_q=0 while out=1.
REQ-030 Enable hold: load a=1, b=0, sel=0, en=1 -> out_q=1; then en=0, a=0 -> out_q stays 1 for 3 edges while out=0.
REQ-031 WIDTH=8: a=8'hA5, b=8'h3C; sel=0 -> out=8'hA5; sel=1 -> out=8'h3C; with en=1, out_q=8'h3C one edge later, sel_q=1.
REQ-032 Reset mid-stream: en=1, toggle sel each cycle, assert reset for one edge -> out_q=0 on that edge; the next edge after release loads the current selection.
REQ-033 Async check: pulse reset high between edges and drop it before the next edge -> out_q and sel_q unchanged.

Source files
------------

// File: rtl/mux.sv
// Two-input multiplexer with a combinational output and an enable-gated
// registered copy of the result and of the select line.
module mux #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q
);

  // The register loads the same select result that drives out, so the two
  // paths cannot disagree about which input was chosen.
  always_comb begin
    out = sel ? b : a;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      sel_q <= 1'b0;
    end else if (en) begin
      out_q <= out;
      sel_q <= sel;
    end
  end

endmodule

// File: tb/tb_mux.sv
// Bench for mux: a WIDTH=1 and a WIDTH=8 instance share clock and control,
// checked against a cycle-level model plus directed literal expectations.
module tb_mux;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       reset = 1'b0;
  logic       sel = 1'b0;
  logic       en = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       out1, out_q1, sel_q1;
  logic [7:0] out8, out_q8;
  logic       sel_q8;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what the registered outputs must hold after each edge.
  logic       model_valid = 1'b0;
  logic       m_q1 = 1'b0, m_s1 = 1'b0, m_s8 = 1'b0;
  logic [7:0] m_q8 = '0;
  logic       cmp_on = 1'b0;

  mux #(.WIDTH(1)) u_mux1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .sel(sel), .en(en),
    .out(out1), .out_q(out_q1), .sel_q(sel_q1)
  );

  mux #(.WIDTH(8)) u_mux8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8), .sel(sel), .en(en),
    .out(out8), .out_q(out_q8), .sel_q(sel_q8)
  );

  // Clock / watchdog
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Model: reset wins, otherwise enable loads the chosen input and sel.
  always @(posedge clk) begin
    if (reset) begin
      m_q1 = 1'b0; m_s1 = 1'b0; m_q8 = '0; m_s8 = 1'b0;
      model_valid = 1'b1;
    end else if (en) begin
      m_q1 = (sel == 1'b1) ? b1 : a1;
      m_s1 = sel;
      m_q8 = (sel == 1'b1) ? b8 : a8;
      m_s8 = sel;
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cmp_out1", 64'(out1), 64'((sel == 1'b1) ? b1 : a1));
      chk("cmp_out8", 64'(out8), 64'((sel == 1'b1) ? b8 : a8));
      if (model_valid) begin
        chk("cmp_out_q1", 64'(out_q1), 64'(m_q1));
        chk("cmp_sel_q1", 64'(sel_q1), 64'(m_s1));
        chk("cmp_out_q8", 64'(out_q8), 64'(m_q8));
        chk("cmp_sel_q8", 64'(sel_q8), 64'(m_s8));
      end
    end
  end

  // Driver tasks
  task automatic at_drive();
    @(negedge clk);
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] truth;
    truth = 8'b1101_1000;

    // Exhaustive WIDTH=1 truth table, clock stopped.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, sel} = 3'(i);
      #1;
      chk($sformatf("truth_%0d", i), 64'(out1), 64'(truth[i]));
    end

    clk_run = 1'b1;
    cmp_on = 1'b1;

    // Reset edge with every input pushing towards one.
    at_drive();
    a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sel = 1'b1; en = 1'b1; reset = 1'b1;
    after_edge();
    chk("rst_out_q1", 64'(out_q1), 64'd0);
    chk("rst_sel_q1", 64'(sel_q1), 64'd0);
    chk("rst_out1", 64'(out1), 64'd1);
    chk("rst_out_q8", 64'(out_q8), 64'd0);

    // Enable hold.
    at_drive();
    reset = 1'b0; a1 = 1'b1; b1 = 1'b0; sel = 1'b0; en = 1'b1; a8 = 8'h5A; b8 = 8'h00;
    after_edge();
    chk("hold_load", 64'(out_q1), 64'd1);
    at_drive();
    en = 1'b0; a1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      after_edge();
      chk($sformatf("hold_q_%0d", k), 64'(out_q1), 64'd1);
      chk($sformatf("hold_out_%0d", k), 64'(out1), 64'd0);
    end

    // WIDTH=8 select and load.
    at_drive();
    a8 = 8'hA5; b8 = 8'h3C; sel = 1'b0;
    #1;
    chk("w8_sel0", 64'(out8), 64'hA5);
    sel = 1'b1;
    #1;
    chk("w8_sel1", 64'(out8), 64'h3C);
    en = 1'b1;
    after_edge();
    chk("w8_out_q", 64'(out_q8), 64'h3C);
    chk("w8_sel_q", 64'(sel_q8), 64'd1);

    // Reset mid-stream while sel toggles.
    a8 = 8'h11; b8 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      at_drive();
      sel = ~sel;
    end
    at_drive();
    sel = ~sel; reset = 1'b1;
    after_edge();
    chk("mid_rst_q", 64'(out_q8), 64'd0);
    chk("mid_rst_s", 64'(sel_q8), 64'd0);
    at_drive();
    reset = 1'b0; sel = 1'b1;
    after_edge();
    chk("post_rst_q", 64'(out_q8), 64'h22);
    chk("post_rst_s", 64'(sel_q8), 64'd1);

    // Reset pulse entirely between edges is not sampled.
    at_drive();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("pulse_q_now", 64'(out_q8), 64'h22);
    chk("pulse_s_now", 64'(sel_q8), 64'd1);
    en = 1'b0;
    after_edge();
    chk("pulse_q_edge", 64'(out_q8), 64'h22);
    chk("pulse_s_edge", 64'(sel_q8), 64'd1);

    // Randomized traffic with mid-cycle data changes.
    for (int n = 0; n < 400; n++) begin
      at_drive();
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      sel = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 15) == 0);
      #2;
      a8 = 8'($urandom_range(0, 255));
      b1 = 1'($urandom_range(0, 1));
      #1;
      chk("mid_out8", 64'(out8), 64'((sel == 1'b1) ? b8 : a8));
      chk("mid_out1", 64'(out1), 64'((sel == 1'b1) ? b1 : a1));
    end

    at_drive();
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
